systolic_input_sequencer: RTL and testbench

SYSTOLIC_INPUT_SEQUENCER -- requirements
Module: systolic_input_sequencer

---
 rtl/systolic_input_sequencer.sv | 123 ++++++++++++
 tb/tb_systolic_input_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_input_sequencer.sv
// Load/feed/drain sequencer for an NxN systolic array: N accepted columns, 2N-1 skewed feed cycles, DRAIN_LAT settle cycles.
// Outputs decode registered state one cycle after the deciding edge; LOAD stalls on in_valid low or any fifo_full, and FEED/DRAIN never stall.
module systolic_input_sequencer #(
    parameter int N         = 4,
    parameter int DRAIN_LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] wen,
    output logic [N-1:0] ren,
    input  logic [N-1:0] fifo_full,
    input  logic [N-1:0] fifo_empty,
    output logic         acc_clr,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int CW  = $clog2(2 * N);
    // The drain counter widens when DRAIN_LAT exceeds 2N so it cannot wrap mid-pass.
    localparam int DWR = $clog2(DRAIN_LAT + 1);
    localparam int DW  = (DWR > CW) ? DWR : CW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] lcnt;
    logic [CW-1:0] t;
    logic [DW-1:0] d;
    logic          acc_clr_q;
    logic          err_q;
    logic          accept;
    logic [N-1:0]  ren_v;

    assign in_ready = (state == S_LOAD) & ~(|fifo_full);
    assign accept   = in_valid & in_ready;
    assign wen      = {N{accept}};
    assign acc_clr  = acc_clr_q;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign err      = err_q;
    assign ren      = ren_v;

    // Diagonal skew: row i is read while t lies in [i, i+N-1].
    always_comb begin
        ren_v = '0;
        for (int i = 0; i < N; i++) begin
            if (state == S_FEED && int'(t) >= i && int'(t) <= i + N - 1) begin
                ren_v[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            lcnt      <= '0;
            t         <= '0;
            d         <= '0;
            acc_clr_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            acc_clr_q <= 1'b0;
            if (|(ren_v & fifo_empty)) begin
                err_q <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        lcnt      <= '0;
                        acc_clr_q <= 1'b1;
                        err_q     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (lcnt == CW'(N - 1)) begin
                            state <= S_FEED;
                            lcnt  <= '0;
                            t     <= '0;
                        end else begin
                            lcnt <= lcnt + CW'(1);
                        end
                    end
                end
                S_FEED: begin
                    if (t == CW'(2 * N - 2)) begin
                        state <= S_DRAIN;
                        t     <= '0;
                        d     <= '0;
                    end else begin
                        t <= t + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (d == DW'(DRAIN_LAT - 1)) begin
                        state <= S_DONE;
                        d     <= '0;
                    end else begin
                        d <= d + DW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_input_sequencer.sv
// Bench for systolic_input_sequencer: directed passes plus random traffic against a timeline model of the pass.
module tb_systolic_input_sequencer;

    localparam int N  = 4;
    localparam int DL = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic [N-1:0] fifo_full = '0;
    logic [N-1:0] fifo_empty = '0;
    logic         in_ready;
    logic [N-1:0] wen;
    logic [N-1:0] ren;
    logic         acc_clr;
    logic         busy;
    logic         done;
    logic         err;

    systolic_input_sequencer #(.N(N), .DRAIN_LAT(DL)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wen        (wen),
        .ren        (ren),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .acc_clr    (acc_clr),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Timeline model: a pass is described by when it began loading, when feeding begins and when done is due.
    bit m_pass, m_load, m_err;
    int m_beats, m_load_start, m_feed_start, m_done_cyc;

    logic [N-1:0] last_ren;
    logic         last_err;
    int           last_done = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Rows read at feed offset k are those whose N-cycle window covers k.
    function automatic logic [N-1:0] ren_mask(input int k);
        int lo, hi, m;
        if (k < 0 || k > 2 * N - 2) return '0;
        lo = (k - N + 1 < 0) ? 0 : k - N + 1;
        hi = (k > N - 1) ? N - 1 : k;
        m  = ((1 << (hi + 1)) - 1) & ~((1 << lo) - 1);
        return N'(m);
    endfunction

    task automatic step(input logic s, input logic v, input logic r,
                        input logic [N-1:0] f, input logic [N-1:0] e);
        logic [N-1:0] er;
        logic [N-1:0] ew;
        logic         erdy;
        @(negedge clk);
        rst = r; start = s; in_valid = v; fifo_full = f; fifo_empty = e;
        #1;
        erdy = m_pass && m_load && !(|f);
        ew   = (erdy && v) ? '1 : '0;
        er   = (m_pass && !m_load) ? ren_mask(cyc - m_feed_start) : '0;
        if (r) begin
            chk("rst_busy", 32'(busy), 0);
            chk("rst_in_ready", 32'(in_ready), 0);
            chk("rst_wen", 32'(wen), 0);
            chk("rst_ren", 32'(ren), 0);
            chk("rst_acc_clr", 32'(acc_clr), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_err", 32'(err), 0);
        end else begin
            chk("busy", 32'(busy), 32'(m_pass));
            chk("acc_clr", 32'(acc_clr), 32'(m_pass && m_load && cyc == m_load_start));
            chk("in_ready", 32'(in_ready), 32'(erdy));
            chk("wen", 32'(wen), 32'(ew));
            chk("ren", 32'(ren), 32'(er));
            chk("done", 32'(done), 32'(m_pass && !m_load && cyc == m_done_cyc));
            chk("err", 32'(err), 32'(m_err));
        end
        last_ren = ren;
        last_err = err;
        if (done) last_done = cyc;
        @(posedge clk);
        if (r) begin
            m_pass = 0; m_load = 0; m_err = 0; m_beats = 0;
        end else begin
            if (|(er & e)) m_err = 1;
            if (!m_pass) begin
                if (s) begin
                    m_pass = 1; m_load = 1; m_beats = 0;
                    m_load_start = cyc + 1; m_err = 0;
                end
            end else if (m_load) begin
                if (erdy && v) begin
                    m_beats++;
                    if (m_beats == N) begin
                        m_load       = 0;
                        m_feed_start = cyc + 1;
                        m_done_cyc   = m_feed_start + (2 * N - 1) + DL;
                    end
                end
            end else if (cyc == m_done_cyc) begin
                m_pass = 0;
            end
        end
        cyc++;
    endtask

    task automatic idle_run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0);
    endtask

    initial begin
        logic [N-1:0] hist [32];
        logic [N-1:0] tbl  [7];
        int           s0;
        tbl = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

        step(0, 0, 1, '0, '0);
        step(1, 1, 1, '0, '0);
        idle_run(2);

        // Nominal pass with an absolute check of the skew table and done latency.
        s0 = cyc;
        step(1, 1, 0, '0, '0);
        hist[0] = last_ren;
        for (int k = 1; k < 20; k++) begin
            step(0, 1, 0, '0, '0);
            hist[k] = last_ren;
        end
        for (int j = 0; j < 7; j++) chk("nom_ren_tbl", 32'(hist[5 + j]), 32'(tbl[j]));
        chk("nom_done_lat", 32'(last_done - s0), 16);

        // Stall on the second beat for three cycles.
        s0 = cyc;
        step(1, 1, 0, '0, '0);
        for (int k = 1; k < 23; k++) step(0, !(k >= 2 && k <= 4), 0, '0, '0);
        chk("stall_done_lat", 32'(last_done - s0), 19);

        // Backpressure from row 2 for two load cycles.
        step(1, 1, 0, '0, '0);
        for (int k = 1; k < 22; k++) step(0, 1, 0, (k == 2 || k == 3) ? 4'b0100 : 4'b0000, '0);

        // Underflow on row 3 at feed t=5; err must persist through done.
        s0 = cyc;
        step(1, 1, 0, '0, '0);
        for (int k = 1; k < 17; k++) step(0, 1, 0, '0, (k == 10) ? 4'b1000 : 4'b0000);
        chk("uf_err_at_done", 32'(last_err), 1);
        idle_run(2);
        step(1, 1, 0, '0, '0);
        step(0, 1, 0, '0, '0);
        chk("uf_err_cleared", 32'(last_err), 0);
        for (int k = 0; k < 18; k++) step(0, 1, 0, '0, '0);

        // Abort at feed t=2, then a fresh full pass.
        step(1, 1, 0, '0, '0);
        for (int k = 1; k < 7; k++) step(0, 1, 0, '0, '0);
        last_done = -1;
        step(0, 1, 1, '0, '0);
        idle_run(12);
        chk("abort_no_done", 32'(last_done), 32'(-1));
        s0 = cyc;
        step(1, 1, 0, '0, '0);
        for (int k = 1; k < 20; k++) step(0, 1, 0, '0, '0);
        chk("post_abort_lat", 32'(last_done - s0), 16);

        // Start held high across back-to-back passes.
        for (int k = 0; k < 40; k++) step(1, 1, 0, '0, '0);
        idle_run(20);

        // Random traffic including rare resets and underflows.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 199) == 0),
                 N'(($urandom_range(0, 9) == 0) ? $urandom : 0),
                 N'(($urandom_range(0, 29) == 0) ? $urandom : 0));
        end
        idle_run(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
